// File: rtl/br_pred_pht.sv
// br_pred_pht: pattern history table of saturating counters indexed by fetch PC.
// Combinational lookup (taken / strong / index used); one training update per
// cycle, landing on the next posedge. Define BR_PRED_PHT_GSHARE_EN to XOR a
// global history register into the lookup index (gshare); otherwise bimodal.
module br_pred_pht #(
  parameter  int PHT_DEPTH = 256,
  parameter  int CTR_WIDTH = 2,
  parameter  int RESET_CTR = 2**(CTR_WIDTH-1),
  parameter  int GHR_WIDTH = 8,
  localparam int IDX_W     = $clog2(PHT_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_valid,
  input  logic [31:0]      pred_pc,
  output logic             pred_taken,
  output logic             pred_strong,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;
  localparam logic [CTR_WIDTH-1:0] CTR_RST = CTR_WIDTH'(RESET_CTR);

  logic [CTR_WIDTH-1:0] ctr [PHT_DEPTH];
  logic [IDX_W-1:0]     hash;
  logic [IDX_W-1:0]     idx;
  logic [CTR_WIDTH-1:0] cur;
  logic [CTR_WIDTH-1:0] old;
  logic [CTR_WIDTH-1:0] nxt;
  logic                 act;

`ifdef BR_PRED_PHT_GSHARE_EN
  logic [GHR_WIDTH-1:0] ghr;

  // Non-speculative history: shift in each resolved outcome, oldest bit drops off
  always_ff @(posedge clk) begin
    if (rst)            ghr <= '0;
    else if (upd_valid) ghr <= GHR_WIDTH'({ghr, upd_taken});
  end

  assign hash = IDX_W'(ghr);
`else
  assign hash = '0;
`endif

  // Lookup: PC word index, optionally hashed with history; reads pre-update state
  always_comb begin
    idx         = pred_pc[IDX_W+1:2] ^ hash;
    cur         = ctr[idx];
    act         = pred_valid & ~rst;
    pred_idx    = pred_valid ? idx : '0;
    pred_taken  = act & cur[CTR_WIDTH-1];
    pred_strong = act & ((cur == '0) | (cur == CTR_MAX));
  end

  // Saturating step for the entry being trained; holds at either end
  always_comb begin
    old = ctr[upd_idx];
    nxt = old;
    if (upd_taken) begin
      if (old != CTR_MAX) nxt = old + CTR_WIDTH'(1);
    end else begin
      if (old != '0)      nxt = old - CTR_WIDTH'(1);
    end
  end

  // Table storage: single-cycle reset of every entry, otherwise one write per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHT_DEPTH; i++) ctr[i] <= CTR_RST;
    end else if (upd_valid) begin
      ctr[upd_idx] <= nxt;
    end
  end

  // PC bits outside the index field never affect the table
  logic unused_pc;
  assign unused_pc = ^{pred_pc[31:IDX_W+2], pred_pc[1:0]};

endmodule

// File: tb/tb_br_pred_pht.sv
// tb_br_pred_pht: directed test-plan steps followed by randomized traffic,
// all compared against a plain-arithmetic model of the counter table.
module tb_br_pred_pht;

  localparam int DEPTH = 256;
  localparam int IW    = 8;
  localparam int W     = 2;
  localparam int CMAX  = (1 << W) - 1;
  localparam int RSTV  = 2;
  localparam int GW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          pred_valid;
  logic [31:0]   pred_pc;
  logic          pred_taken;
  logic          pred_strong;
  logic [IW-1:0] pred_idx;
  logic          upd_valid;
  logic [IW-1:0] upd_idx;
  logic          upd_taken;

  br_pred_pht dut (
    .clk         (clk),
    .rst         (rst),
    .pred_valid  (pred_valid),
    .pred_pc     (pred_pc),
    .pred_taken  (pred_taken),
    .pred_strong (pred_strong),
    .pred_idx    (pred_idx),
    .upd_valid   (upd_valid),
    .upd_idx     (upd_idx),
    .upd_taken   (upd_taken)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int unsigned mdl [DEPTH];
  int unsigned ghr = 0;

  function automatic int unsigned m_idx(input logic [31:0] pc);
    int unsigned i;
    i = (pc / 4) % DEPTH;
`ifdef BR_PRED_PHT_GSHARE_EN
    i = i ^ ghr;
`endif
    return i;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Compare the combinational outputs against the model for the inputs now applied
  task automatic check_pred(input string tag);
    int unsigned ei, c;
    logic et, es;
    #1;
    ei = pred_valid ? m_idx(pred_pc) : 0;
    c  = mdl[m_idx(pred_pc)];
    et = pred_valid && !rst && (c >= (CMAX + 1) / 2);
    es = pred_valid && !rst && (c == 0 || c == CMAX);
    chk({tag, "_idx"},    {24'd0, pred_idx}, ei);
    chk({tag, "_taken"},  {31'd0, pred_taken}, {31'd0, et});
    chk({tag, "_strong"}, {31'd0, pred_strong}, {31'd0, es});
  endtask

  // Advance one clock and apply the same edge to the model
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mdl[i] = RSTV;
      ghr = 0;
    end else if (upd_valid) begin
      if (upd_taken && mdl[upd_idx] < CMAX) mdl[upd_idx] = mdl[upd_idx] + 1;
      else if (!upd_taken && mdl[upd_idx] > 0) mdl[upd_idx] = mdl[upd_idx] - 1;
      ghr = ((ghr << 1) | upd_taken) % (1 << GW);
    end
    #1;
  endtask

  task automatic drive(input logic r, input logic pv, input logic [31:0] pc,
                       input logic uv, input int ui, input logic ut);
    rst        = r;
    pred_valid = pv;
    pred_pc    = pc;
    upd_valid  = uv;
    upd_idx    = IW'(ui);
    upd_taken  = ut;
  endtask

  task automatic upd(input int ui, input logic ut);
    drive(0, 0, 0, 1, ui, ut);
    tick();
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mdl[i] = 0;
    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    do_reset();

    // Reset defaults: weakly taken everywhere
    drive(0, 1, 32'h0, 0, 0, 0);   check_pred("rst_pc0");
    chk("rst_pc0_tk", {31'd0, pred_taken}, 1);
    chk("rst_pc0_st", {31'd0, pred_strong}, 0);
    drive(0, 1, 32'h4, 0, 0, 0);   check_pred("rst_pc4");
    chk("rst_pc4_ix", {24'd0, pred_idx}, 1);
    drive(0, 1, 32'h3FC, 0, 0, 0); check_pred("rst_pc3fc");
    chk("rst_pc3fc_ix", {24'd0, pred_idx}, 255);
    drive(0, 0, 32'h3FC, 0, 0, 0); check_pred("novalid");
    tick();

    // Saturate up, hold at max, then one step back
    do_reset();
    repeat (3) upd(5, 1);
    drive(0, 1, 32'h14, 0, 0, 0); check_pred("sat_up");
    upd(5, 1);
    drive(0, 1, 32'h14, 0, 0, 0); check_pred("sat_hold");
    upd(5, 0);
    drive(0, 1, 32'h14, 0, 0, 0); check_pred("sat_back");

    // Saturate down and hysteresis
    do_reset();
    repeat (3) upd(7, 0);
    drive(0, 1, 32'h1C, 0, 0, 0); check_pred("sat_dn");
    upd(7, 1);
    drive(0, 1, 32'h1C, 0, 0, 0); check_pred("hyst1");
    upd(7, 1);
    drive(0, 1, 32'h1C, 0, 0, 0); check_pred("hyst2");

    // Same-cycle predict + update: no bypass
    do_reset();
    upd(9, 0);
    drive(0, 1, 32'h24, 1, 9, 1);  check_pred("haz_same");
`ifndef BR_PRED_PHT_GSHARE_EN
    chk("haz_same_tk", {31'd0, pred_taken}, 0);
`endif
    tick();
    drive(0, 1, 32'h24, 0, 0, 0);  check_pred("haz_next");
    drive(0, 1, 32'h20, 0, 0, 0);  check_pred("haz_nb8");
    drive(0, 1, 32'h28, 0, 0, 0);  check_pred("haz_nb10");
    tick();

    // Reset beats a concurrent update; outputs forced low during reset
    upd(3, 0); upd(3, 0);
    drive(1, 1, 32'h0C, 1, 3, 0);  check_pred("rst_pri_in");
    tick();
    drive(0, 1, 32'h0C, 0, 0, 0);  check_pred("rst_pri_out");
`ifndef BR_PRED_PHT_GSHARE_EN
    chk("rst_pri_tk", {31'd0, pred_taken}, 1);
`endif

    // History hashing: t, t, nt -> ghr 0x06
    do_reset();
    upd(20, 1); upd(20, 1); upd(20, 0);
    drive(0, 1, 32'h40, 0, 0, 0);  check_pred("gsh");
`ifdef BR_PRED_PHT_GSHARE_EN
    chk("gsh_ix", {24'd0, pred_idx}, 32'h16);
`else
    chk("gsh_ix", {24'd0, pred_idx}, 32'h10);
`endif
    tick();

    // Randomized traffic concentrated on a few entries to force collisions
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 39) == 0),
            ($urandom_range(0, 3) != 0),
            {$urandom_range(0, 255), 24'd0} | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3),
            ($urandom_range(0, 2) != 0),
            $urandom_range(0, 15),
            $urandom_range(0, 1));
      check_pred("rnd");
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/br_pred_pht.md
Name: br_pred_pht

Overview:
- Parametrised pattern history table (PHT): an array of PHT_DEPTH saturating counters, each CTR_WIDTH bits wide, indexed by fetch PC.
- Sits beside fetch. Gives a same-cycle taken/not-taken prediction plus the table index used, which travels down the pipeline with the instruction.
- Trained at branch resolution/commit with the returned index and the actual outcome.
- Successor to the single 2-bit counter: adds depth, counter width, a configurable reset state, a confidence output, and optional global-history hashing.

Parameters:
- PHT_DEPTH, 256, number of counters; power of 2, minimum 2. IDX_W = $clog2(PHT_DEPTH).
- CTR_WIDTH, 2, counter width in bits; minimum 1.
- RESET_CTR, 2**(CTR_WIDTH-1), counter value after reset (weakly taken); must be < 2**CTR_WIDTH.
- GHR_WIDTH, 8, global history length; 1 <= GHR_WIDTH <= IDX_W. Used only with GSHARE_EN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- pred_valid  in  1  fetch lookup request
- pred_pc  in  32  fetch PC
- pred_taken  out  1  predicted direction
- pred_strong  out  1  counter is saturated (0 or 2**CTR_WIDTH-1)
- pred_idx  out  IDX_W  table index used for this lookup
- upd_valid  in  1  training request
- upd_idx  in  IDX_W  index returned with the resolved branch
- upd_taken  in  1  actual outcome

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high, sampled on the posedge of clk.
- Reset:
  - On the posedge with rst=1, every counter is set to RESET_CTR and the GHR is cleared to 0.
  - A concurrent upd_valid is ignored; reset wins.
  - Reset asserted in the middle of training discards all learned state.
- Index:
  - Bimodal: idx = pred_pc[IDX_W+1:2]. PC bits [1:0] are ignored.
  - pred_idx = idx whenever pred_valid=1, and 0 otherwise.
- Prediction (combinational, 0-cycle latency from pred_pc to the outputs):
  - pred_taken = MSB of ctr[idx].
  - pred_strong = 1 when ctr[idx] is all-zeros or all-ones.
  - Both outputs are forced to 0 when pred_valid=0 or rst=1.
- Update (1-cycle latency): on a posedge with upd_valid=1 and rst=0:
  - upd_taken=1: ctr[upd_idx] = min(ctr+1, 2**CTR_WIDTH-1).
  - upd_taken=0: ctr[upd_idx] = max(ctr-1, 0).
  - Saturation is a hold: no wrap-around at either end.
  - Only the entry at upd_idx changes.
- Simultaneous predict and update to the same index in the same cycle: the prediction sees the old (pre-update) value. The new value is visible from the next cycle. There is no bypass.
- One update per cycle. No stall/ready: the block always accepts both requests.
- CTR_WIDTH=1 degenerates to a last-outcome table. pred_strong is then always 1 while valid.
- Storage is flops. Reset must clear all entries in the single reset cycle, with no multi-cycle init sequence.

Optional Feature:
- Macro: BR_PRED_PHT_GSHARE_EN.
- Defined:
  - Adds a GHR_WIDTH-bit global history register, updated non-speculatively on each upd_valid: ghr = {ghr[GHR_WIDTH-2:0], upd_taken}. For GHR_WIDTH=1, ghr = upd_taken.
  - Index becomes pred_pc[IDX_W+1:2] XOR zero-extended ghr, with ghr aligned to the index LSBs.
  - The GHR shift lands at the same posedge as the counter update. A lookup in the same cycle uses the old GHR.
  - The update path still uses upd_idx as given and never recomputes the hash.
- Undefined:
  - No GHR flops; pure bimodal indexing.
  - GHR_WIDTH is unused and must not generate logic.

Test Plan:
- Reset: rst for 1 cycle, then lookups of pred_pc=0x0, 0x4, 0x3FC -> pred_taken=1, pred_strong=0, pred_idx=0, 1, 255 (defaults).
- Saturate up: 3 updates idx=5 taken -> ctr=3. Lookup pc=0x14 -> taken=1, strong=1. A 4th taken update keeps ctr=3; one not-taken update then gives taken=1, strong=0.
- Saturate down and hysteresis: from reset, 3 not-taken updates on idx=7 -> ctr=0, lookup pc=0x1C gives taken=0, strong=1. One taken update -> taken=0; a second -> taken=1.
- Same-cycle hazard: ctr[9]=1. In one cycle, lookup pc=0x24 plus update idx=9 taken -> that cycle pred_taken=0; next cycle pred_taken=1. Entries 8 and 10 are unchanged.
- Reset priority: rst=1 with upd_valid=1 on an entry at ctr=0 -> entry reads 2 afterwards. rst mid-sequence restores all entries to RESET_CTR.
- GSHARE_EN, GHR_WIDTH=8: updates taken, taken, not-taken -> ghr=0x06. Lookup pc=0x40 -> pred_idx=0x10^0x06=0x16. Without the macro -> pred_idx=0x10.
